// File: rtl/vz_pkg.sv
// vz_pkg: shared state encoding and constants for the VZ image loader.
package vz_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_PATCH, S_DONE, S_ERR} vz_state_e;
    localparam logic [15:0] VZ_HDR_LEN     = 16'd24;
    localparam logic [7:0]  VZ_TYPE_BASIC  = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_MCODE  = 8'hF1;
    localparam logic [15:0] VZ_PATCH_BASIC = 16'h78A4;
    localparam logic [15:0] VZ_PATCH_END   = 16'h78F9;
    localparam logic [15:0] VZ_PATCH_USR   = 16'h788E;
    localparam logic [31:0] VZ_MAGIC_VZF0  = 32'h565A4630;
    localparam logic [31:0] VZ_MAGIC_ALT   = 32'h20200000;
endpackage

// File: rtl/vz_ram_arb.sv
// vz_ram_arb: shares the RAM write port between the Z80 (combinational)
// and the loader (one registered write stage).
module vz_ram_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        own,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_din,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we
);
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;

    always_comb begin
        we_d   = ld_we;
        addr_d = ld_we ? ld_addr : addr_q;
        din_d  = ld_we ? ld_din : din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= 16'h0000;
            din_q  <= 8'h00;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    // A loader write still in the stage wins even after the CPU is released.
    always_comb begin
        ram_we   = we_q | (~own & cpu_we);
        ram_addr = we_q ? addr_q : cpu_addr;
        ram_din  = we_q ? din_q : cpu_dout;
    end
endmodule

// File: rtl/vz_loader.sv
// vz_loader: streams a VZ image from the ioctl download bus into main RAM,
// then patches BASIC/USR pointers when VZ_PTR_PATCH_EN is defined.
module vz_loader
    import vz_pkg::*;
#(
    parameter logic [7:0]  VZ_INDEX = 8'd1,
    parameter logic [15:0] RAM_BASE = 16'h7800
) (
    input  logic        CLK50MHZ,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [7:0]  dn_index,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        cpu_wait,
    output logic        busy,
    output logic        err,
    output logic [7:0]  vz_type,
    output logic [15:0] vz_start,
    output logic [15:0] vz_end
);
    vz_state_e   state_q, state_d;
    logic        dl_q, err_q, err_d;
    logic [7:0]  type_q, type_d;
    logic [15:0] start_q, start_d, end_q, end_d;
    logic [23:0] magic_q, magic_d;
    logic        rise, fall, own, ld_we;
    logic [15:0] tgt, ld_addr;
    logic [7:0]  ld_din;

    assign rise = dn_download & ~dl_q & (dn_index == VZ_INDEX);
    assign fall = ~dn_download & dl_q;
    assign tgt  = start_q + dn_addr - VZ_HDR_LEN;
    assign own  = (state_q == S_HDR) | (state_q == S_DATA) | (state_q == S_PATCH);

`ifdef VZ_PTR_PATCH_EN
    logic [1:0]  pcnt_q, pcnt_d;
    logic        basic, p_last;
    logic [15:0] p_addr, p_val;
    assign basic  = type_q == VZ_TYPE_BASIC;
    assign p_addr = (basic ? (pcnt_q[1] ? VZ_PATCH_END : VZ_PATCH_BASIC) : VZ_PATCH_USR) + {15'd0, pcnt_q[0]};
    assign p_val  = (basic && pcnt_q[1]) ? end_q + 16'd1 : start_q;
    assign p_last = basic ? (pcnt_q == 2'd3) : (pcnt_q == 2'd1);
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        type_d  = type_q;
        start_d = start_q;
        end_d   = end_q;
        magic_d = magic_q;
        ld_we   = 1'b0;
        ld_addr = tgt;
        ld_din  = dn_data;
`ifdef VZ_PTR_PATCH_EN
        pcnt_d  = pcnt_q;
`endif
        case (state_q)
            S_HDR: begin
                if (dn_wr) begin
                    if (dn_addr < 16'd3) magic_d = {magic_q[15:0], dn_data};
                    if (dn_addr == 16'd21) type_d = dn_data;
                    if (dn_addr == 16'd22) start_d[7:0] = dn_data;
                    if (dn_addr == 16'd23) begin
                        start_d[15:8] = dn_data;
                        end_d         = {dn_data, start_q[7:0]} - 16'd1;
                        state_d       = S_DATA;
                    end
                end
                if (fall || (dn_wr && dn_addr == 16'd3 && {magic_q, dn_data} != VZ_MAGIC_VZF0
                             && {magic_q, dn_data} != VZ_MAGIC_ALT)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (dn_wr && dn_addr >= VZ_HDR_LEN) begin
                    end_d = tgt;
                    ld_we = tgt >= RAM_BASE;
                end
`ifdef VZ_PTR_PATCH_EN
                if (fall) state_d = S_PATCH;
`else
                if (fall) state_d = S_DONE;
`endif
            end
`ifdef VZ_PTR_PATCH_EN
            S_PATCH: begin
                if (basic || type_q == VZ_TYPE_MCODE) begin
                    ld_we   = 1'b1;
                    ld_addr = p_addr;
                    ld_din  = pcnt_q[0] ? p_val[15:8] : p_val[7:0];
                    pcnt_d  = pcnt_q + 2'd1;
                    if (p_last) state_d = S_DONE;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            default: begin
                if (rise) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    end_d   = 16'h0000;
`ifdef VZ_PTR_PATCH_EN
                    pcnt_d  = 2'd0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= 8'h00;
            start_q <= 16'h0000;
            end_q   <= 16'h0000;
            magic_q <= 24'h000000;
`ifdef VZ_PTR_PATCH_EN
            pcnt_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            dl_q    <= dn_download;
            err_q   <= err_d;
            type_q  <= type_d;
            start_q <= start_d;
            end_q   <= end_d;
            magic_q <= magic_d;
`ifdef VZ_PTR_PATCH_EN
            pcnt_q  <= pcnt_d;
`endif
        end
    end

    assign busy     = own;
    assign cpu_wait = own;
    assign err      = err_q;
    assign vz_type  = type_q;
    assign vz_start = start_q;
    assign vz_end   = end_q;

    vz_ram_arb u_arb (
        .clk      (CLK50MHZ),
        .rst_n    (RESET),
        .own      (own),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_din   (ld_din),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we)
    );
endmodule

// File: doc/vz_loader.md
# vz_loader

Sequences a VZ image download (OSD file slot F1) from the `dn_*` ioctl stream into the Laser 310 main RAM, sharing the single RAM write port with the Z80. It parses the 24-byte VZ header, streams the payload to the load address while holding the CPU in wait, then patches the BASIC or USR pointers. It sits inside `LASER310_TOP` between the download bus, the CPU memory interface and the RAM.

## Interface
- `VZ_INDEX`, 8'd1: `dn_index` value that selects a VZ load.
- `RAM_BASE`, 16'h7800: lowest writable RAM address; payload writes below it are dropped.
- `CLK50MHZ` in 1: system clock.
- `RESET` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `dn_download`, `dn_wr`, `dn_index[7:0]`, `dn_addr[15:0]`, `dn_data[7:0]` in: ioctl download stream. `dn_wr` is a one-cycle strobe.
- `cpu_addr` in 16: Z80 address.
- `cpu_dout` in 8: Z80 write data.
- `cpu_we` in 1: Z80 RAM write request.
- `ram_addr` out 16, `ram_din` out 8, `ram_we` out 1: shared RAM port.
- `cpu_wait` out 1: Z80 WAIT request, active high.
- `busy` out 1: high while a load is in progress (LED).
- `err` out 1: sticky header error, cleared when the next load starts.
- `vz_type` out 8, `vz_start` out 16, `vz_end` out 16: parsed header fields and the last address written.

## Operation
- States: IDLE, HDR, DATA, PATCH, DONE, ERR.
- Leave IDLE, DONE or ERR for HDR on a rising `dn_download` with `dn_index==VZ_INDEX`. This clears `err`, `vz_end` and the patch counter.
- HDR: capture bytes by `dn_addr`.
  - Bytes 0–3 are the magic. Accept `"VZF0"` or `20 20 00 00`; anything else goes to ERR at byte 3.
  - Bytes 4–20 are the name and are ignored.
  - Byte 21 is the type.
  - Bytes 22–23 are the start address, low byte first.
  - After byte 23, go to DATA.
- DATA: a byte at offset n≥24 writes to `vz_start + (n-24)`.
  - The address is 16-bit and wraps from FFFF to 0000.
  - A target address below `RAM_BASE` gives no write, but `vz_end` still advances.
- PATCH: entered when `dn_download` falls in DATA.
  - Type F0: four writes in this order. 78A4 = start lo, 78A5 = start hi, 78F9 = (end+1) lo, 78FA = (end+1) hi.
  - Type F1: two writes. 788E = start lo, 788F = start hi.
  - Any other type: no writes.
  - Then go to DONE.
- `dn_download` falling during HDR goes to ERR. A zero-length payload (fall right after byte 23) patches with end = start − 1.
- Arbitration:
  - In HDR, DATA and PATCH, `cpu_wait=1` and the RAM port belongs to the loader. `cpu_we` is ignored and is not queued.
  - In IDLE, DONE and ERR, the RAM port passes the CPU through combinationally (`ram_we=cpu_we`).
- `busy=1` in HDR, DATA and PATCH.

## Timing
- Reset values:
  - state IDLE.
  - `ram_we`, `cpu_wait`, `busy`, `err` all 0.
  - `vz_type`, `vz_start`, `vz_end` all 0.
  - `ram_addr` and `ram_din` follow the CPU inputs.
- Payload write latency: `dn_wr` in cycle t gives a registered `ram_we`, `ram_addr` and `ram_din` in cycle t+1, one cycle wide.
- PATCH issues one write per cycle, back to back. F0 takes 4 cycles and F1 takes 2, then DONE.
- `cpu_wait` rises in the cycle after the `dn_download` rise is detected. It falls in the cycle DONE or ERR is entered.
- If a `dn_wr` arrives in the same cycle that `dn_download` falls, write the byte first, then enter PATCH.
- A rising `dn_download` with another index is ignored; state and CPU passthrough are unchanged.
- Reset asserted mid-load returns to IDLE immediately, drops `cpu_wait` and abandons the partial image.

## Configuration
- `VZ_PTR_PATCH_EN` defined: PATCH behaves as above.
- `VZ_PTR_PATCH_EN` undefined: PATCH is compiled out and DATA goes straight to DONE on the `dn_download` fall. The `vz_type` output remains.

## Structure
- Package `vz_pkg` holds:
  - the state enum;
  - constants `VZ_HDR_LEN=24`, `VZ_TYPE_BASIC=8'hF0`, `VZ_TYPE_MCODE=8'hF1`;
  - the patch addresses 78A4, 78F9 and 788E;
  - the two magic values.
- One sub-module, `vz_ram_arb`: the combinational CPU/loader mux plus the registered loader write stage.

## Test plan
- Valid F0 image with start 7AE9 and 3 bytes `AA BB CC`:
  - writes 7AE9=AA, 7AEA=BB, 7AEB=CC;
  - then 78A4=E9, 78A5=7A, 78F9=EC, 78FA=7A;
  - `cpu_wait` is high throughout, then 0 and DONE.
- F1 image with start 8000 and 2 bytes: data goes to 8000–8001, then 788E=00, 788F=80, with no 78A4 write.
- Magic `"XXXX"`: ERR after byte 3, `err=1`, no `ram_we` from the loader, CPU writes pass through afterward.
- Start FFFF with 2 bytes: writes FFFF, then the 0000 write is suppressed (below `RAM_BASE`), and `vz_end=0000`.
- `cpu_we` pulse during DATA: no CPU write reaches RAM and `cpu_wait=1`. `cpu_we` in DONE reaches RAM in the same cycle.
- `RESET` low during byte 30: state IDLE, `cpu_wait=0`, `busy=0` asynchronously, and no further loader writes.
